// File: rtl/ps2_mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_packet_decoder
//  Description : Assembles 3-byte PS/2 mouse packets from the controller byte
//                stream and keeps a clamped absolute cursor position and the
//                button state. Resynchronises on bad header bytes and on
//                inter-byte timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet_decoder #(
    parameter int COORD_W = 10,
    parameter int X_MAX   = 639,
    parameter int Y_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 1000000
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [7:0]         received_data,
    input  logic               received_data_en,
    output logic [COORD_W-1:0] mouse_x,
    output logic [COORD_W-1:0] mouse_y,
    output logic [2:0]         buttons,
    output logic               packet_valid,
    output logic               framing_error
);

    // Sum width leaves room for sign and for a full 9-bit delta on top of the
    // largest coordinate.
    localparam int c_SUM_W = COORD_W + 2;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    localparam logic signed [c_SUM_W-1:0] c_X_MAX_S = c_SUM_W'(X_MAX);
    localparam logic signed [c_SUM_W-1:0] c_Y_MAX_S = c_SUM_W'(Y_MAX);
    localparam logic [c_CNT_W-1:0]        c_TIMEOUT = c_CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_ID   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_B3   = 3'd4
    } state_t;

    state_t               r_state;
    logic [7:0]           r_b1;
    logic [7:0]           r_b2;
    logic [c_CNT_W-1:0]   r_cnt;

    logic signed [c_SUM_W-1:0] w_dx;
    logic signed [c_SUM_W-1:0] w_dy;
    logic signed [c_SUM_W-1:0] w_x_sum;
    logic signed [c_SUM_W-1:0] w_y_sum;
    logic [COORD_W-1:0]        w_x_next;
    logic [COORD_W-1:0]        w_y_next;

    // The third byte is used straight from the input so the packet applies on
    // the edge that captures it.
    assign w_dx    = {{(c_SUM_W-9){r_b1[4]}}, r_b1[4], r_b2};
    assign w_dy    = {{(c_SUM_W-9){r_b1[5]}}, r_b1[5], received_data};
    assign w_x_sum = $signed({2'b00, mouse_x}) + w_dx;
    assign w_y_sum = $signed({2'b00, mouse_y}) - w_dy;

    // Next cursor position: hold on overflow, otherwise clamp to the screen.
    always_comb begin
        w_x_next = mouse_x;
        w_y_next = mouse_y;
        if (!r_b1[6]) begin
            if (w_x_sum[c_SUM_W-1])
                w_x_next = '0;
            else if (w_x_sum > c_X_MAX_S)
                w_x_next = COORD_W'(X_MAX);
            else
                w_x_next = w_x_sum[COORD_W-1:0];
        end
        if (!r_b1[7]) begin
            if (w_y_sum[c_SUM_W-1])
                w_y_next = '0;
            else if (w_y_sum > c_Y_MAX_S)
                w_y_next = COORD_W'(Y_MAX);
            else
                w_y_next = w_y_sum[COORD_W-1:0];
        end
    end

    // Packet framing FSM, inter-byte timeout and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state       <= S_INIT;
            r_b1          <= '0;
            r_b2          <= '0;
            r_cnt         <= '0;
            mouse_x       <= COORD_W'(X_INIT);
            mouse_y       <= COORD_W'(Y_INIT);
            buttons       <= '0;
            packet_valid  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            packet_valid  <= 1'b0;
            framing_error <= 1'b0;
            if (received_data_en) begin
                // A byte always wins over a coincident timeout.
                r_cnt <= '0;
                case (r_state)
                    S_INIT: begin
                        if (received_data == 8'hFA) begin
                            r_state <= S_INIT;      // command ack, ignored
                        end else if (received_data == 8'hAA) begin
                            r_state <= S_ID;
                        end else if (received_data[3]) begin
                            r_b1    <= received_data;
                            r_state <= S_B2;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                    S_ID: begin
                        r_state <= S_INIT;          // device ID byte dropped
                    end
                    S_B1: begin
                        if (received_data == 8'hAA) begin
                            r_state <= S_ID;        // hot-plug self-test
                        end else if (received_data[3]) begin
                            r_b1    <= received_data;
                            r_state <= S_B2;
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                    S_B2: begin
                        r_b2    <= received_data;
                        r_state <= S_B3;
                    end
                    S_B3: begin
                        mouse_x      <= w_x_next;
                        mouse_y      <= w_y_next;
                        buttons      <= r_b1[2:0];
                        packet_valid <= 1'b1;
                        r_state      <= S_B1;
                    end
                    default: begin
                        r_state <= S_INIT;
                    end
                endcase
            end else if (r_state == S_B2 || r_state == S_B3) begin
                if (r_cnt == c_TIMEOUT) begin
                    framing_error <= 1'b1;
                    r_cnt         <= '0;
                    r_state       <= S_B1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_mouse_packet_decoder
//  Description : Self-checking bench for ps2_mouse_packet_decoder: a table of
//                packets with hand-computed cursor/button results plus short
//                sequences for framing errors, timeout and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packet_decoder;

    localparam int c_TIMEOUT = 40;
    localparam int c_NVEC    = 20;

    logic       clk;
    logic       rst;
    logic [7:0] r_data;
    logic       r_en;
    logic [9:0] w_x;
    logic [9:0] w_y;
    logic [2:0] w_btn;
    logic       w_pv;
    logic       w_fe;

    int n_vec  = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int pv_cnt = 0;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         ex;
        int         ey;
        int         eb;
    } vec_t;

    vec_t tbl [c_NVEC];

    ps2_mouse_packet_decoder #(
        .COORD_W (10),
        .X_MAX   (639),
        .Y_MAX   (479),
        .X_INIT  (320),
        .Y_INIT  (240),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (rst),
        .received_data    (r_data),
        .received_data_en (r_en),
        .mouse_x          (w_x),
        .mouse_y          (w_y),
        .buttons          (w_btn),
        .packet_valid     (w_pv),
        .framing_error    (w_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (w_fe) fe_cnt++;
        if (w_pv) pv_cnt++;
        if (w_fe && w_pv) begin
            n_vec++;
            n_fail++;
            $display("FAIL pulse_exclusive: framing_error=%0b packet_valid=%0b, required not both 1", w_fe, w_pv);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        r_data = b;
        r_en   = 1'b1;
        @(negedge clk);
        r_en   = 1'b0;
    endtask

    // Three strobes on consecutive cycles; returns on the first negedge after
    // the third byte has been captured.
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        r_data = a;
        r_en   = 1'b1;
        @(negedge clk);
        r_data = b;
        @(negedge clk);
        r_data = c;
        @(negedge clk);
        r_en   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int fe0;
        int pv0;
        int k;
        bit seen;

        tbl[0]  = '{8'h08, 8'h05, 8'h03, 325, 237, 0};
        tbl[1]  = '{8'h18, 8'hF6, 8'h00, 315, 237, 0};
        tbl[2]  = '{8'h18, 8'h80, 8'h00, 187, 237, 0};
        tbl[3]  = '{8'h18, 8'h80, 8'h00,  59, 237, 0};
        tbl[4]  = '{8'h18, 8'h80, 8'h00,   0, 237, 0};
        tbl[5]  = '{8'h18, 8'h80, 8'h00,   0, 237, 0};
        tbl[6]  = '{8'h08, 8'h7F, 8'h00, 127, 237, 0};
        tbl[7]  = '{8'h0F, 8'h10, 8'h00, 143, 237, 7};
        tbl[8]  = '{8'h08, 8'h00, 8'h7F, 143, 110, 0};
        tbl[9]  = '{8'h28, 8'h00, 8'h80, 143, 238, 0};
        tbl[10] = '{8'h28, 8'h00, 8'h00, 143, 479, 0};
        tbl[11] = '{8'h28, 8'h00, 8'hFF, 143, 479, 0};
        tbl[12] = '{8'h08, 8'h00, 8'hFF, 143, 224, 0};
        tbl[13] = '{8'h08, 8'h00, 8'hFF, 143,   0, 0};
        tbl[14] = '{8'h08, 8'hFF, 8'h00, 398,   0, 0};
        tbl[15] = '{8'h08, 8'hFF, 8'h00, 639,   0, 0};
        tbl[16] = '{8'h28, 8'h00, 8'hC8, 639,  56, 0};
        tbl[17] = '{8'h58, 8'hFF, 8'h01, 639,  55, 0};
        tbl[18] = '{8'h9A, 8'hF6, 8'h7F, 629,  55, 2};
        tbl[19] = '{8'h38, 8'hAA, 8'hFA, 543,  61, 0};

        rst    = 1'b1;
        r_data = 8'h00;
        r_en   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_x", int'(w_x), 320);
        chk("reset_y", int'(w_y), 240);
        chk("reset_btn", int'(w_btn), 0);
        chk("reset_pv", int'(w_pv), 0);
        chk("reset_fe", int'(w_fe), 0);

        // Ack byte is silently dropped.
        send_byte(8'hFA);
        chk("ack_no_fe", fe_cnt, 0);

        for (int i = 0; i < c_NVEC; i++) begin
            send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2);
            chk($sformatf("v%0d_pv", i), int'(w_pv), 1);
            chk($sformatf("v%0d_x", i), int'(w_x), tbl[i].ex);
            chk($sformatf("v%0d_y", i), int'(w_y), tbl[i].ey);
            chk($sformatf("v%0d_btn", i), int'(w_btn), tbl[i].eb);
            @(negedge clk);
            chk($sformatf("v%0d_pv_width", i), int'(w_pv), 0);
        end
        chk("table_pv_count", pv_cnt, c_NVEC);
        chk("table_no_fe", fe_cnt, 0);

        // Header byte without bit3 in S_B1.
        fe0 = fe_cnt;
        pv0 = pv_cnt;
        send_byte(8'h07);
        chk("bad_hdr_fe", fe_cnt - fe0, 1);
        chk("bad_hdr_no_pv", pv_cnt - pv0, 0);
        send_pkt(8'h09, 8'h00, 8'h00);
        chk("resync_btn", int'(w_btn), 1);
        chk("resync_x", int'(w_x), 543);
        chk("resync_y", int'(w_y), 61);

        // Inter-byte timeout after the second byte.
        fe0 = fe_cnt;
        pv0 = pv_cnt;
        send_byte(8'h08);
        send_byte(8'h05);
        k = 0;
        seen = 1'b0;
        while (!seen && k < c_TIMEOUT + 10) begin
            @(negedge clk);
            k++;
            if (w_fe) seen = 1'b1;
        end
        chk("timeout_seen", int'(seen), 1);
        chk("timeout_late_enough", int'(k >= c_TIMEOUT), 1);
        chk("timeout_early_enough", int'(k <= c_TIMEOUT + 2), 1);
        chk("timeout_no_pv", pv_cnt - pv0, 0);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk("after_to_x", int'(w_x), 544);
        chk("after_to_y", int'(w_y), 60);
        chk("after_to_btn", int'(w_btn), 0);
        chk("timeout_fe_count", fe_cnt - fe0, 1);

        // Self-test + ID in S_B1, then two packets back to back.
        fe0 = fe_cnt;
        pv0 = pv_cnt;
        send_byte(8'hAA);
        send_byte(8'h00);
        chk("selftest_no_fe", fe_cnt - fe0, 0);
        @(negedge clk);
        r_data = 8'h08; r_en = 1'b1;
        @(negedge clk);
        r_data = 8'h01;
        @(negedge clk);
        r_data = 8'h00;
        @(negedge clk);
        r_data = 8'h08;
        @(negedge clk);
        r_data = 8'h01;
        @(negedge clk);
        r_data = 8'h00;
        @(negedge clk);
        r_en = 1'b0;
        @(negedge clk);
        chk("b2b_pv_count", pv_cnt - pv0, 2);
        chk("b2b_x", int'(w_x), 546);
        chk("b2b_y", int'(w_y), 60);

        // Reset in the middle of a packet.
        send_byte(8'h58);
        send_byte(8'hFF);
        do_reset();
        @(negedge clk);
        chk("midrst_x", int'(w_x), 320);
        chk("midrst_y", int'(w_y), 240);
        chk("midrst_btn", int'(w_btn), 0);
        fe0 = fe_cnt;
        send_byte(8'h07);
        chk("init_bad_fe", fe_cnt - fe0, 1);
        send_byte(8'hFA);
        chk("init_ack_no_fe", fe_cnt - fe0, 1);
        send_pkt(8'h08, 8'h02, 8'h00);
        chk("post_rst_x", int'(w_x), 322);
        chk("post_rst_y", int'(w_y), 240);
        chk("post_rst_pv", int'(w_pv), 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
